// File: rtl/data_forward_unit.sv
// data_forward_unit: hazard forwarding selects plus saturating forwarding-event counters; WB-stage forwarding enabled by DATA_FWD_WB_EN
module data_forward_unit #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       RsD,
  input  logic [4:0]       RtD,
  input  logic [4:0]       RegM,
  input  logic [4:0]       RegW,
  input  logic [4:0]       WriteRegE,
  input  logic             RegWriteM,
  input  logic             RegWriteW,
  input  logic             RegWriteE,
  input  logic             BranchD,
  input  logic             cnt_clr,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             ForwardAD,
  output logic             ForwardBD,
  output logic [CNT_W-1:0] fwd_mem_cnt,
  output logic [CNT_W-1:0] fwd_wb_cnt,
  output logic [CNT_W-1:0] fwd_br_cnt
);
`ifdef DATA_FWD_WB_EN
  localparam logic WB_EN = 1'b1;
`else
  localparam logic WB_EN = 1'b0;
`endif
  logic             m_ok, w_ok, e_ok;
  logic [1:0]       mem_inc, wb_inc, br_inc;
  logic [CNT_W-1:0] mem_q, mem_d, wb_q, wb_d, br_q, br_d;
  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] q, input logic [1:0] n);
    logic [CNT_W:0] s;
    s = {1'b0, q} + (CNT_W+1)'(n);
    return s[CNT_W] ? '1 : s[CNT_W-1:0];
  endfunction
  // forwarding selects: MEM beats WB, register 0 never forwarded
  always_comb begin
    m_ok      = RegWriteM && (RegM != 5'd0);
    w_ok      = WB_EN && RegWriteW && (RegW != 5'd0);
    e_ok      = BranchD && RegWriteE && (WriteRegE != 5'd0);
    ForwardAE = (m_ok && RegM == RsD) ? 2'b10 : (w_ok && RegW == RsD) ? 2'b01 : 2'b00;
    ForwardBE = (m_ok && RegM == RtD) ? 2'b10 : (w_ok && RegW == RtD) ? 2'b01 : 2'b00;
    ForwardAD = e_ok && (WriteRegE == RsD);
    ForwardBD = e_ok && (WriteRegE == RtD);
  end
  // per-cycle event counts and saturating next counter values, clear wins
  always_comb begin
    mem_inc = {1'b0, ForwardAE == 2'b10} + {1'b0, ForwardBE == 2'b10};
    wb_inc  = {1'b0, ForwardAE == 2'b01} + {1'b0, ForwardBE == 2'b01};
    br_inc  = {1'b0, ForwardAD} + {1'b0, ForwardBD};
    mem_d   = cnt_clr ? '0 : sat_add(mem_q, mem_inc);
    wb_d    = cnt_clr ? '0 : sat_add(wb_q, wb_inc);
    br_d    = cnt_clr ? '0 : sat_add(br_q, br_inc);
  end
  // counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q <= '0;
      wb_q  <= '0;
      br_q  <= '0;
    end else begin
      mem_q <= mem_d;
      wb_q  <= wb_d;
      br_q  <= br_d;
    end
  end
  assign fwd_mem_cnt = mem_q;
  assign fwd_wb_cnt  = wb_q;
  assign fwd_br_cnt  = br_q;
endmodule

// File: tb/tb_data_forward_unit.sv
// tb_data_forward_unit: table-driven forwarding checks plus counter saturation/clear/reset sequences
module tb_data_forward_unit;
`ifdef DATA_FWD_WB_EN
  localparam logic [1:0] W = 2'b01;
`else
  localparam logic [1:0] W = 2'b00;
`endif
  logic clk = 1'b0, rst_n = 1'b0, cnt_clr = 1'b0;
  logic [4:0] RsD, RtD, RegM, RegW, WriteRegE;
  logic RegWriteM, RegWriteW, RegWriteE, BranchD;
  logic [1:0] ForwardAE, ForwardBE;
  logic ForwardAD, ForwardBD;
  logic [1:0] fwd_mem_cnt, fwd_wb_cnt, fwd_br_cnt;
  int tests = 0, fails = 0;
  typedef struct {
    logic [4:0] rs, rt, rm, rw, re;
    logic wm, ww, we, br;
    logic [1:0] ae, be;
    logic ad, bd;
  } vec_t;
  vec_t tv[10];

  data_forward_unit #(.CNT_W(2)) dut (
    .clk(clk), .rst_n(rst_n), .RsD(RsD), .RtD(RtD), .RegM(RegM), .RegW(RegW),
    .WriteRegE(WriteRegE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .RegWriteE(RegWriteE), .BranchD(BranchD), .cnt_clr(cnt_clr),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .ForwardAD(ForwardAD),
    .ForwardBD(ForwardBD), .fwd_mem_cnt(fwd_mem_cnt), .fwd_wb_cnt(fwd_wb_cnt),
    .fwd_br_cnt(fwd_br_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic apply(input vec_t v);
    RsD = v.rs; RtD = v.rt; RegM = v.rm; RegW = v.rw; WriteRegE = v.re;
    RegWriteM = v.wm; RegWriteW = v.ww; RegWriteE = v.we; BranchD = v.br;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_cnt(input string name, input logic [1:0] m, input logic [1:0] w, input logic [1:0] b);
    chk({name, " mem"}, 32'(fwd_mem_cnt), 32'(m));
    chk({name, " wb"}, 32'(fwd_wb_cnt), 32'(w));
    chk({name, " br"}, 32'(fwd_br_cnt), 32'(b));
  endtask

  initial begin
    //           rs     rt     rm     rw     re     wm    ww    we    br    ae     be     ad    bd
    tv[0] = '{5'd0,  5'd0,  5'd0,  5'd0,  5'd0,  1'b1, 1'b1, 1'b1, 1'b1, 2'b00, 2'b00, 1'b0, 1'b0};
    tv[1] = '{5'd10, 5'd10, 5'd10, 5'd10, 5'd10, 1'b1, 1'b1, 1'b1, 1'b1, 2'b10, 2'b10, 1'b1, 1'b1};
    tv[2] = '{5'd10, 5'd10, 5'd10, 5'd10, 5'd10, 1'b1, 1'b1, 1'b1, 1'b0, 2'b10, 2'b10, 1'b0, 1'b0};
    tv[3] = '{5'd10, 5'd10, 5'd10, 5'd10, 5'd10, 1'b0, 1'b1, 1'b1, 1'b0, W,     W,     1'b0, 1'b0};
    tv[4] = '{5'd10, 5'd10, 5'd10, 5'd10, 5'd10, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0};
    tv[5] = '{5'd10, 5'd10, 5'd10, 5'd10, 5'd10, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 1'b0, 1'b0};
    tv[6] = '{5'd10, 5'd5,  5'd5,  5'd10, 5'd0,  1'b1, 1'b1, 1'b0, 1'b0, W,     2'b10, 1'b0, 1'b0};
    tv[7] = '{5'd7,  5'd0,  5'd0,  5'd7,  5'd0,  1'b0, 1'b1, 1'b0, 1'b0, W,     2'b00, 1'b0, 1'b0};
    tv[8] = '{5'd3,  5'd4,  5'd3,  5'd4,  5'd4,  1'b1, 1'b1, 1'b1, 1'b1, 2'b10, W,     1'b0, 1'b1};
    tv[9] = '{5'd3,  5'd4,  5'd3,  5'd4,  5'd3,  1'b1, 1'b1, 1'b1, 1'b0, 2'b10, W,     1'b0, 1'b0};
    apply(tv[1]);
    #2;
    chk_cnt("reset", 2'd0, 2'd0, 2'd0);
    chk("AE in reset", 32'(ForwardAE), 32'(2'b10));
    chk("AD in reset", 32'(ForwardAD), 32'd1);
    #6 rst_n = 1'b1;
    cnt_clr = 1'b1;
    for (int i = 0; i < 10; i++) begin
      apply(tv[i]);
      #1;
      chk($sformatf("v%0d AE", i), 32'(ForwardAE), 32'(tv[i].ae));
      chk($sformatf("v%0d BE", i), 32'(ForwardBE), 32'(tv[i].be));
      chk($sformatf("v%0d AD", i), 32'(ForwardAD), 32'(tv[i].ad));
      chk($sformatf("v%0d BD", i), 32'(ForwardBD), 32'(tv[i].bd));
    end
    tick;
    chk_cnt("cleared", 2'd0, 2'd0, 2'd0);
    apply(tv[1]);
    cnt_clr = 1'b0;
    tick;
    chk_cnt("hold1", 2'd2, 2'd0, 2'd2);
    tick;
    chk_cnt("hold2", 2'd3, 2'd0, 2'd3);
    tick;
    chk_cnt("hold3", 2'd3, 2'd0, 2'd3);
    cnt_clr = 1'b1;
    tick;
    chk_cnt("clr prio", 2'd0, 2'd0, 2'd0);
    cnt_clr = 1'b0;
    tick;
    chk_cnt("recount", 2'd2, 2'd0, 2'd2);
    #3 rst_n = 1'b0;
    #1;
    chk_cnt("async rst", 2'd0, 2'd0, 2'd0);
    chk("AE during rst", 32'(ForwardAE), 32'(2'b10));
    #2 rst_n = 1'b1;
    tick;
    chk_cnt("resume", 2'd2, 2'd0, 2'd2);
    apply(tv[3]);
    cnt_clr = 1'b1;
    tick;
    cnt_clr = 1'b0;
    tick;
    chk_cnt("wb count", 2'd0, (W == 2'b01) ? 2'd2 : 2'd0, 2'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
